// File: rtl/avg_pool_2x2.sv
// 2x2 average pooling of a raster pixel stream: horizontal pair sums of even
// rows wait in a half-width line buffer and combine with the odd-row pairs.
module avg_pool_2x2 #(
    parameter int IMG_ROW = 540,
    parameter int IMG_COL = 540
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       done_o,
    output logic [8:0] out_row_o,
    output logic [8:0] out_col_o
);

    localparam int HALF_COL = IMG_COL / 2;
    localparam logic [9:0] LAST_IN_COL  = 10'(IMG_COL - 1);
    localparam logic [9:0] LAST_IN_ROW  = 10'(IMG_ROW - 1);
    localparam logic [8:0] LAST_OUT_COL = 9'(IMG_COL / 2 - 1);
    localparam logic [8:0] LAST_OUT_ROW = 9'(IMG_ROW / 2 - 1);

    logic [9:0] in_col, in_row;
    logic [8:0] out_col, out_row;
    logic [7:0] px_prev;
    logic [8:0] line_buf [HALF_COL];

    logic [8:0] pair;
    logic [8:0] buf_idx;
    logic [9:0] sum;
    logic [7:0] avg;
    logic       accept, write_line, emit;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        accept     = valid_i && !clear_i && !rst;
        pair       = {1'b0, px_prev} + {1'b0, data_i};
        buf_idx    = in_col[9:1];
        sum        = {1'b0, line_buf[buf_idx]} + {1'b0, pair};
        avg        = 8'((sum + 10'd2) >> 2);
        write_line = accept && in_col[0] && !in_row[0];
        emit       = accept && in_col[0] && in_row[0];
    end

    // NOTE: the line buffer has no reset; each entry is rewritten on an even
    // row before an odd row reads it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (write_line) begin
            line_buf[buf_idx] <= pair;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            in_col    <= '0;
            in_row    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            px_prev   <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            done_o    <= 1'b0;
            out_row_o <= '0;
            out_col_o <= '0;
        end else begin
            data_o  <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            if (valid_i) begin
                if (in_col == LAST_IN_COL) begin
                    in_col <= '0;
                    in_row <= (in_row == LAST_IN_ROW) ? '0 : in_row + 10'd1;
                end else begin
                    in_col <= in_col + 10'd1;
                end
                if (!in_col[0]) begin
                    px_prev <= data_i;
                end
            end
            if (emit) begin
                data_o    <= avg;
                valid_o   <= 1'b1;
                done_o    <= (out_row == LAST_OUT_ROW) && (out_col == LAST_OUT_COL);
                out_row_o <= out_row;
                out_col_o <= out_col;
                if (out_col == LAST_OUT_COL) begin
                    out_col <= '0;
                    out_row <= (out_row == LAST_OUT_ROW) ? '0 : out_row + 9'd1;
                end else begin
                    out_col <= out_col + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_avg_pool_2x2.sv
// Self-checking bench for avg_pool_2x2 on a reduced frame size; expected
// outputs come from a plain 2D-array model of the pooled image.
module tb_avg_pool_2x2;

    localparam int ROWS = 8;
    localparam int COLS = 10;
    localparam int HR   = ROWS / 2;
    localparam int HC   = COLS / 2;
    localparam int NOUT = HR * HC;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       done_o;
    logic [8:0] out_row_o;
    logic [8:0] out_col_o;

    always #5 clk = ~clk;

    avg_pool_2x2 #(.IMG_ROW(ROWS), .IMG_COL(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .done_o    (done_o),
        .out_row_o (out_row_o),
        .out_col_o (out_col_o)
    );

    typedef struct {
        logic [7:0] data;
        logic [8:0] row;
        logic [8:0] col;
        logic       done;
        int         cyc;
    } out_t;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   zero_viol    = 0;
    bit   mon_en       = 1'b0;
    out_t obs_q[$];
    out_t exp_q[$];
    int   trig_q[$];
    int   img [ROWS][COLS];

    always @(posedge clk) cyc++;

    // Capture every output; outside valid_o the data and done lines must be 0.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            if (valid_o === 1'b1) begin
                obs_q.push_back('{data_o, out_row_o, out_col_o, done_o, cyc});
            end else if (data_o !== 8'd0 || done_o !== 1'b0) begin
                zero_viol++;
            end
        end
    end

    function automatic logic [7:0] avg4(int a, int b, int c, int d);
        return 8'((a + b + c + d + 2) / 4);
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < HR; r++) begin
            for (int c = 0; c < HC; c++) begin
                exp_q.push_back('{avg4(img[2*r][2*c], img[2*r][2*c+1],
                                       img[2*r+1][2*c], img[2*r+1][2*c+1]),
                                  9'(r), 9'(c), (r == HR - 1) && (c == HC - 1), 0});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_pixel(input logic [7:0] d);
        valid_i = 1'b1;
        data_i  = d;
        step();
        valid_i = 1'b0;
        data_i  = 8'd0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                drive_pixel(8'(img[r][c]));
                if (r % 2 == 1 && c % 2 == 1) trig_q.push_back(cyc);
                if (gap_max > 0) idle($urandom_range(gap_max, 0));
            end
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = $urandom_range(255, 0);
    endtask

    task automatic fill_gradient();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = (r + c) % 256;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'($urandom_range(255, 0));
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({data_o, valid_o, done_o, out_row_o, out_col_o} !== 29'd0) begin
                tests_failed++;
                $display("FAIL reset_state cycle %0d: data=%0d valid=%0b done=%0b row=%0d col=%0d, want all 0",
                         i, data_o, valid_o, done_o, out_row_o, out_col_o);
            end
        end
        rst     = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'd0;
        step();
        mon_en = 1'b1;
    endtask

    task automatic test_arith();
        int blk [4][4] = '{'{1, 2, 3, 4}, '{0, 0, 0, 2}, '{0, 0, 0, 1}, '{255, 255, 255, 255}};
        logic [7:0] want;
        for (int k = 0; k < 4; k++) begin
            do_clear();
            drive_pixel(8'(blk[k][0]));
            drive_pixel(8'(blk[k][1]));
            for (int c = 2; c < COLS; c++) drive_pixel(8'($urandom_range(255, 0)));
            drive_pixel(8'(blk[k][2]));
            drive_pixel(8'(blk[k][3]));
            want = avg4(blk[k][0], blk[k][1], blk[k][2], blk[k][3]);
            tests_run++;
            if (valid_o !== 1'b1 || data_o !== want) begin
                tests_failed++;
                $display("FAIL arith_block%0d: valid=%0b data=%0d, want valid=1 data=%0d",
                         k, valid_o, data_o, want);
            end
        end
        do_clear();
        idle(2);
    endtask

    task automatic test_constant();
        int done_cnt = 0;
        int gap_bad  = 0;
        int data_bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = 100;
        obs_q.delete();
        zero_viol = 0;
        send_frame(0);
        idle(2);
        tests_run++;
        if (obs_q.size() != NOUT) begin
            tests_failed++;
            $display("FAIL const_count: got %0d outputs, want %0d", obs_q.size(), NOUT);
        end
        foreach (obs_q[i]) begin
            if (obs_q[i].data !== 8'd100) data_bad++;
            if (obs_q[i].done === 1'b1) done_cnt++;
            if (i > 0 && obs_q[i].row == obs_q[i-1].row && obs_q[i].cyc - obs_q[i-1].cyc != 2) gap_bad++;
        end
        tests_run++;
        if (data_bad != 0) begin
            tests_failed++;
            $display("FAIL const_data: %0d outputs differ from 100", data_bad);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL const_done_count: got %0d done pulses, want 1", done_cnt);
        end
        if (obs_q.size() > 0) begin
            tests_run++;
            if ({obs_q[$].done, obs_q[$].row, obs_q[$].col} !== {1'b1, 9'(HR - 1), 9'(HC - 1)}) begin
                tests_failed++;
                $display("FAIL const_last: done=%0b row=%0d col=%0d, want done=1 row=%0d col=%0d",
                         obs_q[$].done, obs_q[$].row, obs_q[$].col, HR - 1, HC - 1);
            end
        end
        tests_run++;
        if (gap_bad != 0) begin
            tests_failed++;
            $display("FAIL const_spacing: %0d same-row outputs not 2 cycles apart", gap_bad);
        end
        tests_run++;
        if (zero_viol != 0) begin
            tests_failed++;
            $display("FAIL const_idle_zero: %0d idle cycles with nonzero data/done", zero_viol);
        end
    endtask

    task automatic test_gapped();
        for (int pass = 0; pass < 2; pass++) begin
            fill_random();
            build_expected();
            obs_q.delete();
            trig_q.delete();
            zero_viol = 0;
            send_frame(pass == 0 ? 0 : 5);
            idle(2);
            tests_run++;
            if (obs_q.size() != NOUT) begin
                tests_failed++;
                $display("FAIL gap%0d_count: got %0d outputs, want %0d", pass, obs_q.size(), NOUT);
            end
            for (int i = 0; i < NOUT && i < obs_q.size(); i++) begin
                tests_run++;
                if ({obs_q[i].data, obs_q[i].row, obs_q[i].col, obs_q[i].done}
                    !== {exp_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].done}
                    || obs_q[i].cyc != trig_q[i]) begin
                    tests_failed++;
                    $display("FAIL gap%0d_out%0d: data=%0d row=%0d col=%0d done=%0b cyc=%0d, want data=%0d row=%0d col=%0d done=%0b cyc=%0d",
                             pass, i, obs_q[i].data, obs_q[i].row, obs_q[i].col, obs_q[i].done, obs_q[i].cyc,
                             exp_q[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].done, trig_q[i]);
                end
            end
            tests_run++;
            if (zero_viol != 0) begin
                tests_failed++;
                $display("FAIL gap%0d_idle_zero: %0d idle cycles with nonzero data/done", pass, zero_viol);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_gradient();
        build_expected();
        for (int r = 0; r < HR; r++)
            for (int c = 0; c < COLS; c++)
                drive_pixel(8'($urandom_range(255, 0)));
        for (int c = 0; c < 3; c++) drive_pixel(8'($urandom_range(255, 0)));
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs_q.delete();
        send_frame(0);
        idle(2);
        tests_run++;
        if (obs_q.size() != NOUT) begin
            tests_failed++;
            $display("FAIL rstmid_count: got %0d outputs, want %0d", obs_q.size(), NOUT);
        end
        if (obs_q.size() > 0) begin
            tests_run++;
            if ({obs_q[0].data, obs_q[0].row, obs_q[0].col} !== {8'd1, 9'd0, 9'd0}) begin
                tests_failed++;
                $display("FAIL rstmid_first: data=%0d row=%0d col=%0d, want data=1 row=0 col=0",
                         obs_q[0].data, obs_q[0].row, obs_q[0].col);
            end
        end
        for (int i = 0; i < NOUT && i < obs_q.size(); i++) begin
            tests_run++;
            if ({obs_q[i].data, obs_q[i].done} !== {exp_q[i].data, exp_q[i].done}) begin
                tests_failed++;
                $display("FAIL rstmid_out%0d: data=%0d done=%0b, want data=%0d done=%0b",
                         i, obs_q[i].data, obs_q[i].done, exp_q[i].data, exp_q[i].done);
            end
        end
    endtask

    task automatic test_clear_collision();
        fill_random();
        img[0][0] = 7;
        build_expected();
        clear_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'd200;
        step();
        clear_i = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'd0;
        obs_q.delete();
        send_frame(0);
        idle(2);
        tests_run++;
        if (obs_q.size() != NOUT) begin
            tests_failed++;
            $display("FAIL clear_count: got %0d outputs, want %0d", obs_q.size(), NOUT);
        end
        for (int i = 0; i < NOUT && i < obs_q.size(); i++) begin
            tests_run++;
            if ({obs_q[i].data, obs_q[i].row, obs_q[i].col} !== {exp_q[i].data, exp_q[i].row, exp_q[i].col}) begin
                tests_failed++;
                $display("FAIL clear_out%0d: data=%0d row=%0d col=%0d, want data=%0d row=%0d col=%0d",
                         i, obs_q[i].data, obs_q[i].row, obs_q[i].col, exp_q[i].data, exp_q[i].row, exp_q[i].col);
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_pos[$];
        fill_random();
        build_expected();
        obs_q.delete();
        send_frame(0);
        send_frame(0);
        idle(2);
        tests_run++;
        if (obs_q.size() != 2 * NOUT) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d outputs, want %0d", obs_q.size(), 2 * NOUT);
        end
        foreach (obs_q[i]) if (obs_q[i].done === 1'b1) done_pos.push_back(i);
        tests_run++;
        if (done_pos.size() != 2 || done_pos[0] != NOUT - 1 || done_pos[1] != 2 * NOUT - 1) begin
            tests_failed++;
            $display("FAIL b2b_done: got %0d done pulses (first at %0d), want 2 at %0d and %0d",
                     done_pos.size(), done_pos.size() > 0 ? done_pos[0] : -1, NOUT - 1, 2 * NOUT - 1);
        end
        for (int i = 0; i < 2 * NOUT && i < obs_q.size(); i++) begin
            tests_run++;
            if ({obs_q[i].data, obs_q[i].row, obs_q[i].col} !== {exp_q[i % NOUT].data, exp_q[i % NOUT].row, exp_q[i % NOUT].col}) begin
                tests_failed++;
                $display("FAIL b2b_out%0d: data=%0d row=%0d col=%0d, want data=%0d row=%0d col=%0d",
                         i, obs_q[i].data, obs_q[i].row, obs_q[i].col,
                         exp_q[i % NOUT].data, exp_q[i % NOUT].row, exp_q[i % NOUT].col);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_constant();
        test_gapped();
        test_reset_mid();
        test_clear_collision();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
